bcm_panel_scanner: RTL and testbench

Parametrised scan engine for HUB75-style LED panels (32x32 adaFruit and larger). It drives pixels with binary-coded modulation (BCM) instead of compare-against-counter PWM, and supports any panel width, row count and colour depth. It reads a double-buffered frame store through a synchronous-RAM read port and hands off buffers at frame boundaries. It sits between the controller/frame store and the panel pins.

---
 rtl/bcm_panel_scanner.sv | 170 +++++++++++++++++
 tb/tb_bcm_panel_scanner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_panel_scanner.sv
// HUB75 panel scan engine using binary-coded modulation: shifts one bit plane per row,
// latches it, then shows it for BCM_BASE<<plane cycles; frame buffers swap only at frame end.
module bcm_panel_scanner #(
    parameter int CDEPTH        = 4,
    parameter int COL_BITS      = 5,
    parameter int ROW_BITS      = 4,
    parameter int MCLK_DIV_BITS = 2,
    parameter int BCM_BASE      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         swap_req,
    output logic [ROW_BITS+COL_BITS-1:0] raddr,
    input  logic [3*CDEPTH-1:0]          rdata_lo,
    input  logic [3*CDEPTH-1:0]          rdata_hi,
    output logic                         buf_sel,
    output logic                         swap_ack,
    output logic                         frame_done,
    output logic [2:0]                   rgb1,
    output logic [2:0]                   rgb2,
    output logic [ROW_BITS-1:0]          rsel,
    output logic                         mclk,
    output logic                         latch,
    output logic                         oe_n
);
    localparam int AW = ROW_BITS + COL_BITS;
    localparam int TW = CDEPTH + $clog2(BCM_BASE);
    localparam int PW = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_BLANK = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_SHOW  = 3'd5;

    logic [2:0]               state, state_n;
    logic [ROW_BITS-1:0]      row, row_n, rsel_n;
    logic [PW-1:0]            plane, plane_n;
    logic [COL_BITS-1:0]      col, col_n;
    logic [MCLK_DIV_BITS-1:0] div, div_n;
    logic [TW-1:0]            timer, timer_n, show_last;
    logic [AW-1:0]            raddr_n;
    logic [2:0]               rgb1_n, rgb2_n;
    logic                     buf_sel_n, last_plane, frame_end;

    assign show_last  = (TW'(BCM_BASE) << plane) - TW'(1);
    assign last_plane = (plane == PW'(CDEPTH - 1));
    assign frame_end  = (state == S_SHOW) && (timer == show_last) && last_plane && (&row);
    assign frame_done = frame_end;
    assign swap_ack   = frame_end && swap_req;

    // NOTE: every signal gets a hold default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to remember the old value.
    always_comb begin
        state_n   = state;
        row_n     = row;
        plane_n   = plane;
        col_n     = col;
        div_n     = div;
        timer_n   = timer;
        raddr_n   = raddr;
        rgb1_n    = rgb1;
        rgb2_n    = rgb2;
        rsel_n    = rsel;
        buf_sel_n = buf_sel;
        case (state)
            S_IDLE: if (en) begin
                state_n = S_FETCH;
                row_n   = '0;
                plane_n = '0;
            end
            S_FETCH: begin
                state_n = S_SHIFT;
                div_n   = '0;
            end
            S_SHIFT: begin
                div_n = div + MCLK_DIV_BITS'(1);
                // Read data for this column arrives now; prefetch the next column.
                if (div == '0) begin
                    for (int k = 0; k < 3; k++) begin
                        rgb1_n[k] = rdata_lo[k*CDEPTH + int'(plane)];
                        rgb2_n[k] = rdata_hi[k*CDEPTH + int'(plane)];
                    end
                    if (col != '1)
                        raddr_n = {row, col + COL_BITS'(1)};
                end
                if (&div) begin
                    col_n = col + COL_BITS'(1);
                    if (&col)
                        state_n = S_BLANK;
                end
            end
            S_BLANK: begin
                state_n = S_LATCH;
                timer_n = '0;
                rsel_n  = row;
            end
            S_LATCH: begin
                timer_n = timer + TW'(1);
                if (timer == TW'(1)) begin
                    state_n = S_SHOW;
                    timer_n = '0;
                end
            end
            S_SHOW: begin
                timer_n = timer + TW'(1);
                if (timer == show_last) begin
                    timer_n = '0;
                    state_n = S_FETCH;
                    if (!last_plane) begin
                        plane_n = plane + PW'(1);
                    end else begin
                        plane_n = '0;
                        row_n   = row + ROW_BITS'(1);
                        if (&row) begin
                            if (swap_req)
                                buf_sel_n = ~buf_sel;
                            if (!en)
                                state_n = S_IDLE;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n == S_FETCH) begin
            raddr_n = {row_n, COL_BITS'(0)};
            col_n   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            row     <= '0;
            plane   <= '0;
            col     <= '0;
            div     <= '0;
            timer   <= '0;
            raddr   <= '0;
            rgb1    <= '0;
            rgb2    <= '0;
            rsel    <= '0;
            buf_sel <= 1'b0;
            mclk    <= 1'b0;
            latch   <= 1'b0;
            oe_n    <= 1'b1;
        end else begin
            state   <= state_n;
            row     <= row_n;
            plane   <= plane_n;
            col     <= col_n;
            div     <= div_n;
            timer   <= timer_n;
            raddr   <= raddr_n;
            rgb1    <= rgb1_n;
            rgb2    <= rgb2_n;
            rsel    <= rsel_n;
            buf_sel <= buf_sel_n;
            // Panel strobes are registered from next-state so they are glitch-free.
            mclk    <= (state_n == S_SHIFT) && div_n[MCLK_DIV_BITS-1];
            latch   <= (state_n == S_LATCH);
            oe_n    <= (state_n != S_SHOW);
        end
    end
endmodule

// File: tb/tb_bcm_panel_scanner.sv
// Bench for bcm_panel_scanner: small config cycle table plus swap/en/reset sequences,
// and a default-config instance for row-select sequencing and address wrap.
module tb_bcm_panel_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Small configuration instance
    logic       en_s, swap_req_s, buf_sel_s, swap_ack_s, frame_done_s;
    logic       mclk_s, latch_s, oe_n_s;
    logic [2:0] raddr_s, rgb1_s, rgb2_s;
    logic [5:0] rdata_lo_s, rdata_hi_s;
    logic [0:0] rsel_s;
    logic [5:0] mem_lo [8];
    logic [5:0] mem_hi [8];

    bcm_panel_scanner #(.CDEPTH(2), .COL_BITS(2), .ROW_BITS(1), .MCLK_DIV_BITS(1), .BCM_BASE(2)) dut_s (
        .clk(clk), .reset(reset), .en(en_s), .swap_req(swap_req_s), .raddr(raddr_s),
        .rdata_lo(rdata_lo_s), .rdata_hi(rdata_hi_s), .buf_sel(buf_sel_s), .swap_ack(swap_ack_s),
        .frame_done(frame_done_s), .rgb1(rgb1_s), .rgb2(rgb2_s), .rsel(rsel_s), .mclk(mclk_s),
        .latch(latch_s), .oe_n(oe_n_s)
    );

    always @(posedge clk) begin
        rdata_lo_s <= mem_lo[raddr_s];
        rdata_hi_s <= mem_hi[raddr_s];
    end

    // Default configuration instance
    logic        en_d, swap_req_d, buf_sel_d, swap_ack_d, frame_done_d;
    logic        mclk_d, latch_d, oe_n_d;
    logic [8:0]  raddr_d;
    logic [2:0]  rgb1_d, rgb2_d;
    logic [11:0] rdata_lo_d, rdata_hi_d;
    logic [3:0]  rsel_d;

    bcm_panel_scanner dut_d (
        .clk(clk), .reset(reset), .en(en_d), .swap_req(swap_req_d), .raddr(raddr_d),
        .rdata_lo(rdata_lo_d), .rdata_hi(rdata_hi_d), .buf_sel(buf_sel_d), .swap_ack(swap_ack_d),
        .frame_done(frame_done_d), .rgb1(rgb1_d), .rgb2(rgb2_d), .rsel(rsel_d), .mclk(mclk_d),
        .latch(latch_d), .oe_n(oe_n_d)
    );

    always @(posedge clk) begin
        rdata_lo_d <= {3{raddr_d[3:0]}};
        rdata_hi_d <= ~{3{raddr_d[3:0]}};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic       oe_n;
        logic       latch;
        logic       mclk;
        logic [2:0] rgb1;
        logic [2:0] rgb2;
        logic       rsel;
        logic [2:0] raddr;
        logic       fd;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    // Cycle 0 is the FETCH cycle after the edge that samples en=1 in IDLE.
    initial begin
        vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1,  1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{2,  1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'd1, 1'b0};
        vecs[3]  = '{3,  1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd1, 1'b0};
        vecs[4]  = '{4,  1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'd2, 1'b0};
        vecs[5]  = '{8,  1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[6]  = '{9,  1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[7]  = '{10, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[8]  = '{11, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[9]  = '{12, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[10] = '{13, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[11] = '{14, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0};
        vecs[12] = '{16, 1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 3'd1, 1'b0};
        vecs[13] = '{17, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 3'd1, 1'b0};
        vecs[14] = '{18, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'd2, 1'b0};
        vecs[15] = '{26, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 1'b0};
        vecs[16] = '{30, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd4, 1'b0};
        vecs[17] = '{38, 1'b1, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 3'd7, 1'b0};
        vecs[18] = '{40, 1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 1'b1, 3'd7, 1'b0};
        vecs[19] = '{42, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 3'd7, 1'b0};
        vecs[20] = '{59, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'd7, 1'b1};
        vecs[21] = '{60, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'd0, 1'b0};
    end

    initial begin
        int vi, rises, run, exp_run, last_fd, show_cnt, lit_cnt, idle_bad, lc, fd_seen;
        logic mclk_q, latch_q, oe_q, cap, found, dlatch_q;
        logic [13:0] got_v, exp_v;

        for (int a = 0; a < 8; a++) begin
            mem_lo[a] = '0;
            mem_hi[a] = '0;
        end
        mem_lo[0] = 6'b000010;   // R=2'b10 at row0 col0
        mem_hi[7] = 6'b000100;   // G=2'b01 at row1 col3

        reset = 1'b1; en_s = 1'b0; en_d = 1'b0; swap_req_s = 1'b0; swap_req_d = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_small", {raddr_s, rgb1_s, rgb2_s, rsel_s, mclk_s, latch_s, oe_n_s, buf_sel_s, swap_ack_s, frame_done_s},
              {3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_default", {raddr_d, rgb1_d, rgb2_d, rsel_d, mclk_d, latch_d, oe_n_d, buf_sel_d, swap_ack_d, frame_done_d},
              {9'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

        en_s = 1'b1;
        @(posedge clk);
        vi = 0; rises = 0; run = 0; exp_run = 2; last_fd = -1; show_cnt = 0; lit_cnt = 0; idle_bad = 0;
        mclk_q = 1'b0; latch_q = 1'b0; oe_q = 1'b1; cap = 1'b0;
        for (int cyc = 0; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (vi < NV) begin
                if (vecs[vi].cyc == cyc) begin
                    got_v = {oe_n_s, latch_s, mclk_s, rgb1_s, rgb2_s, rsel_s, raddr_s, frame_done_s};
                    exp_v = {vecs[vi].oe_n, vecs[vi].latch, vecs[vi].mclk, vecs[vi].rgb1, vecs[vi].rgb2,
                             vecs[vi].rsel, vecs[vi].raddr, vecs[vi].fd};
                    check($sformatf("vec_cyc%0d", cyc), 32'(got_v), 32'(exp_v));
                    vi++;
                end
            end
            if (mclk_s && !mclk_q) begin
                if (rises == 0) cap = rgb1_s[0];
                rises++;
                if (cyc >= 240) idle_bad++;
            end
            if (latch_s && !latch_q) begin
                check("mclk_rises_before_latch", 32'(rises), 32'd4);
                rises = 0;
            end
            if (!oe_n_s) begin
                run++;
                if (rsel_s == 1'b0 && cyc < 60) begin
                    show_cnt++;
                    if (cap) lit_cnt++;
                end
                if (cyc >= 240) idle_bad++;
            end else if (!oe_q) begin
                check("oe_low_run", 32'(run), 32'(exp_run));
                exp_run = (exp_run == 2) ? 4 : 2;
                run = 0;
            end
            if (frame_done_s) begin
                check("frame_period", 32'(cyc - last_fd), 32'd60);
                last_fd = cyc;
            end
            if (cyc == 59)  check("no_swap_first_frame", {swap_ack_s, buf_sel_s}, 2'b00);
            if (cyc == 60)  check("bcm_show_total", 32'(show_cnt), 32'd6);
            if (cyc == 60)  check("bcm_show_lit", 32'(lit_cnt), 32'd4);
            if (cyc == 100) check("no_midframe_swap", {31'd0, buf_sel_s}, 32'd0);
            if (cyc == 119) check("swap_ack_at_frame_end", {frame_done_s, swap_ack_s, buf_sel_s}, 3'b110);
            if (cyc == 120) check("buf_sel_toggled", {swap_ack_s, buf_sel_s}, 2'b01);
            if (cyc == 179) check("no_swap_req_hold", {frame_done_s, swap_ack_s, buf_sel_s}, 3'b101);
            if (cyc == 180) check("buf_sel_holds", {31'd0, buf_sel_s}, 32'd1);
            if (cyc == 239) check("en_low_frame_completes", {31'd0, frame_done_s}, 32'd1);
            if (cyc == 300) check("idle_dark_no_mclk", 32'(idle_bad), 32'd0);
            if (cyc == 300) check("last_frame_done_cycle", 32'(last_fd), 32'd239);
            if (cyc == 70)  swap_req_s = 1'b1;
            if (cyc == 125) swap_req_s = 1'b0;
            if (cyc == 200) en_s = 1'b0;
            if (cyc == 300) en_s = 1'b1;
            mclk_q = mclk_s; latch_q = latch_s; oe_q = oe_n_s;
        end

        // Reset during LATCH
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (latch_s) begin
                found = 1'b1;
                break;
            end
        end
        check("latch_reached", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_latch", {latch_s, oe_n_s, mclk_s, raddr_s, rsel_s, buf_sel_s, frame_done_s},
              {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (k == 0)  check("restart_fetch", {oe_n_s, latch_s, raddr_s}, {1'b1, 1'b0, 3'd0});
            if (k == 10) check("restart_row0_latch", {latch_s, rsel_s}, 2'b10);
            if (k == 59) check("restart_frame_done", {31'd0, frame_done_s}, 32'd1);
        end
        en_s = 1'b0;

        // Default configuration: row-select order and address wrap
        en_d = 1'b1;
        @(posedge clk);
        lc = 0; fd_seen = 0; dlatch_q = 1'b0;
        for (int k = 0; k < 12000 && lc < 68; k++) begin
            @(negedge clk);
            if (latch_d && !dlatch_q) begin
                check($sformatf("rsel_latch%0d", lc), 32'(rsel_d), 32'((lc / 4) % 16));
                lc++;
            end
            if (fd_seen == 1) begin
                check("raddr_wraps_to_0", 32'(raddr_d), 32'd0);
                fd_seen = 2;
            end
            if (frame_done_d && fd_seen == 0) begin
                check("default_frame_len", 32'(k), 32'd10367);
                check("raddr_at_frame_end", 32'(raddr_d), 32'd511);
                fd_seen = 1;
            end
            dlatch_q = latch_d;
        end
        check("default_latch_count", 32'(lc), 32'd68);
        check("default_frame_seen", 32'(fd_seen), 32'd2);
        en_d = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
